// File: rtl/ic_74165_tx.sv
// ic_74165_tx: framed parallel-in/serial-out transmitter on a 74165-style
// shift core. A load captures D, then the word goes out MSB-first on Q7,
// framed by a start bit (0) and a stop bit (1). Each bit is held for
// BIT_CYCLES enabled clock edges.
//
// Optional macro: IC_74165_TX_PARITY_EN inserts an even-parity bit
// between the last data bit and the stop bit.
//
// Ports:
//   CP    in   clock, rising edge
//   RD    in   async active-low reset
//   nCE   in   active-low clock enable; high freezes everything
//   D     in   parallel word, sampled only on an accepted load
//   LOAD  in   load request (level), honoured only in IDLE
//   Q7    out  serial data, idles high
//   nQ7   out  complement of Q7
//   BUSY  out  frame in progress
//   DONE  out  one-cycle pulse on the edge that ends the frame
module ic_74165_tx #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic             CP,
  input  logic             RD,
  input  logic             nCE,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD,
  output logic             Q7,
  output logic             nQ7,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef IC_74165_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  localparam logic [7:0] CYC_LAST = 8'(BIT_CYCLES - 1);
  localparam logic [4:0] BIT_LAST = 5'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [4:0]       bit_q, bit_d;
  logic [7:0]       cyc_q, cyc_d;
  logic             q7_d, busy_d, done_d;
  logic             bit_end;
`ifdef IC_74165_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  // With BIT_CYCLES=1 the counter sits at 0 and every edge ends a bit.
  assign bit_end = (cyc_q == CYC_LAST);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    cyc_d   = cyc_q;
    q7_d    = Q7;
    busy_d  = BUSY;
    done_d  = 1'b0;
`ifdef IC_74165_TX_PARITY_EN
    par_d   = par_q;
`endif

    if (state_q != S_IDLE)
      cyc_d = bit_end ? 8'd0 : cyc_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        q7_d   = 1'b1;
        busy_d = 1'b0;
        if (LOAD) begin
          sr_d    = D;
`ifdef IC_74165_TX_PARITY_EN
          par_d   = ^D;
`endif
          busy_d  = 1'b1;
          q7_d    = 1'b0;
          cyc_d   = 8'd0;
          bit_d   = 5'd0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          q7_d    = sr_q[WIDTH-1];
          bit_d   = 5'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
`ifdef IC_74165_TX_PARITY_EN
            q7_d    = par_q;
            state_d = S_PARITY;
`else
            q7_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            // Q7 always mirrors the register MSB; next bit is one below it.
            sr_d  = sr_q << 1;
            q7_d  = sr_q[WIDTH-2];
            bit_d = bit_q + 5'd1;
          end
        end
      end
`ifdef IC_74165_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          q7_d    = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          q7_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        q7_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CP or negedge RD) begin
    if (!RD) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      Q7      <= 1'b1;
      nQ7     <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
`ifdef IC_74165_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (!nCE) begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      Q7      <= q7_d;
      nQ7     <= ~q7_d;
      BUSY    <= busy_d;
      DONE    <= done_d;
`ifdef IC_74165_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end else begin
      // Disabled edge: everything holds, but a pending DONE pulse drops.
      DONE <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ic_74165_tx.sv
// Directed bench for ic_74165_tx at WIDTH=8, BIT_CYCLES=2. Outputs are
// sampled on the falling edge; inputs change there too.
module tb_ic_74165_tx;

  localparam int W  = 8;
  localparam int BC = 2;
`ifdef IC_74165_TX_PARITY_EN
  localparam int NB = W + 3;
`else
  localparam int NB = W + 2;
`endif

  logic         CP = 1'b0;
  logic         RD, nCE, LOAD;
  logic [W-1:0] D;
  logic         Q7, nQ7, BUSY, DONE;

  int n_tests = 0;
  int n_fail  = 0;

  ic_74165_tx #(.WIDTH(W), .BIT_CYCLES(BC)) dut (
    .CP(CP), .RD(RD), .nCE(nCE), .D(D), .LOAD(LOAD),
    .Q7(Q7), .nQ7(nQ7), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CP = ~CP;

  // got/exp packed as {Q7, nQ7, BUSY, DONE}
  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b (Q7 nQ7 BUSY DONE)", tag, got, exp);
    end
  endtask

  // Frame bit b: 0 start, 1..W data MSB first, [parity], then stop.
  function automatic logic exp_bit(input logic [W-1:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= W) return d[W-b];
`ifdef IC_74165_TX_PARITY_EN
    if (b == W + 1) return ^d;
`endif
    return 1'b1;
  endfunction

  // Request a frame with d; switch D to d2 mid-frame. hold keeps LOAD high.
  // stall_at: sample index after which nCE is held high for 7 edges (-1 none).
  task automatic run_frame(input logic [W-1:0] d, input logic [W-1:0] d2,
                           input bit hold, input int stall_at);
    logic eb;
    D = d; LOAD = 1'b1;
    @(negedge CP);
    if (!hold) LOAD = 1'b0;
    for (int i = 0; i < NB*BC; i++) begin
      if (i == 5) D = d2;
      eb = exp_bit(d, i / BC);
      chk($sformatf("frame_%h_s%0d", d, i), {Q7, nQ7, BUSY, DONE}, {eb, ~eb, 2'b10});
      if (i == stall_at) begin
        nCE = 1'b1;
        for (int k = 0; k < 7; k++) begin
          @(negedge CP);
          chk($sformatf("stall_%h_s%0d_%0d", d, i, k), {Q7, nQ7, BUSY, DONE}, {eb, ~eb, 2'b10});
        end
        nCE = 1'b0;
      end
      @(negedge CP);
    end
    chk($sformatf("done_%h", d), {Q7, nQ7, BUSY, DONE}, 4'b1001);
  endtask

  initial begin
    RD = 1'b0; nCE = 1'b0; LOAD = 1'b0; D = '0;
    @(negedge CP);
    chk("reset_state", {Q7, nQ7, BUSY, DONE}, 4'b1000);
    RD = 1'b1;

    // Mid-sim reset, release with LOAD low: idle for 10 cycles.
    @(negedge CP); RD = 1'b0;
    #1 chk("reset_mid", {Q7, nQ7, BUSY, DONE}, 4'b1000);
    @(negedge CP); RD = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CP);
      chk($sformatf("idle_%0d", i), {Q7, nQ7, BUSY, DONE}, 4'b1000);
    end

    // Basic frame; D changes after acceptance are ignored.
    run_frame(8'hA5, 8'h5A, 1'b0, -1);
    @(negedge CP);
    chk("after_basic", {Q7, nQ7, BUSY, DONE}, 4'b1000);

    // Back-to-back with LOAD held: the STOP-ending edge ignores LOAD, leaving
    // one idle cycle (the DONE sample), then FF (the D present) is accepted.
    run_frame(8'h3C, 8'hFF, 1'b1, -1);
    run_frame(8'hFF, 8'hFF, 1'b0, -1);
    // A disabled edge still drops DONE.
    nCE = 1'b1;
    @(negedge CP);
    chk("done_drop_nce", {Q7, nQ7, BUSY, DONE}, 4'b1000);
    nCE = 1'b0;
    @(negedge CP);

    // Clock enable stall during a data bit (frame grows to 27 cycles).
    run_frame(8'hA5, 8'h00, 1'b0, 8);
    @(negedge CP);
    // Stall over the last STOP cycle: no DONE while frozen.
    run_frame(8'hC3, 8'h3C, 1'b0, NB*BC - 1);
    @(negedge CP);

    // Abort mid-frame with a 3 ns reset pulse.
    D = 8'hA5; LOAD = 1'b1;
    @(negedge CP); LOAD = 1'b0;
    repeat (9) @(negedge CP);
    chk("abort_pre", {Q7, nQ7, BUSY, DONE}, {exp_bit(8'hA5, 9/BC), ~exp_bit(8'hA5, 9/BC), 2'b10});
    #1 RD = 1'b0;
    #1 chk("abort_now", {Q7, nQ7, BUSY, DONE}, 4'b1000);
    #2 RD = 1'b1;
    @(negedge CP);
    chk("abort_idle", {Q7, nQ7, BUSY, DONE}, 4'b1000);
    run_frame(8'h81, 8'h7E, 1'b0, -1);

`ifdef IC_74165_TX_PARITY_EN
    @(negedge CP);
    run_frame(8'hA5, 8'h00, 1'b0, -1);
    @(negedge CP);
    run_frame(8'h07, 8'h00, 1'b0, -1);
`endif

    @(negedge CP);
    chk("final_idle", {Q7, nQ7, BUSY, DONE}, 4'b1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ic_74165_tx.md
Name: ic_74165_tx

Overview:
- Framed parallel-in/serial-out transmitter built around a 74165-style shift core.
- It captures a parallel word, then drives it MSB-first on a single serial line, framed by one start bit and one stop bit.
- Each bit is held for a programmable number of clock cycles.
- It is the transmit end paired with our D-flip-flop and 74164-style serial-capture parts, and is used to send data between chip models in system benches.

Parameters:
- WIDTH, 8, data word width in bits (legal range 2..16).
- BIT_CYCLES, 4, CP cycles per serial bit (legal range 1..255).

Ports:
- CP  input  1  clock; all state updates on rising edge.
- RD  input  1  asynchronous active-low reset (direct reset), overrides everything.
- nCE  input  1  active-low clock enable; when high, all state is frozen.
- D  input  WIDTH  parallel data word, sampled only on an accepted load.
- LOAD  input  1  load request, active-high, level-sampled.
- Q7  output  1  serial data out; idles high.
- nQ7  output  1  complement of Q7 at all times.
- BUSY  output  1  high while a frame is in progress.
- DONE  output  1  one-cycle pulse marking frame completion.

Behaviour:
- Reset (RD=0, asynchronous, immediate, including mid-frame):
  - Q7=1, nQ7=0, BUSY=0, DONE=0.
  - State=IDLE; shift register, bit counter and cycle counter cleared.
- Release: the first rising CP with RD=1 is a normal edge.
- Registers: all outputs are registered; nQ7 is always ~Q7, and Q7 and nQ7 are never equal.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- nCE=1 at an edge: no state, counter, output or shift change, and LOAD is ignored. DONE is forced 0 on that edge.
- IDLE:
  - Q7=1, BUSY=0.
  - Edge with LOAD=1 and nCE=0: latch D into the shift register, BUSY<=1, Q7<=0, state<=START, cycle counter<=0.
- Bit timing: each bit is held exactly BIT_CYCLES enabled edges. When the cycle counter reaches BIT_CYCLES-1, the next enabled edge advances to the next bit and resets the counter.
- START: Q7=0 for one bit time, then Q7<=D[WIDTH-1] and state<=DATA.
- DATA:
  - Shifts left once per bit time; Q7 takes bits D[WIDTH-1] down to D[0].
  - The bit counter counts WIDTH bits, then the state moves to STOP (or PARITY).
- STOP: Q7=1 for one bit time.
- Frame end: on the edge ending STOP, state<=IDLE, BUSY<=0, DONE<=1 for exactly one cycle. DONE is 0 on every other edge.
- Frame length: (WIDTH+2)*BIT_CYCLES enabled cycles, measured from the accepting edge to the edge where BUSY falls.
- LOAD while BUSY=1 is ignored, including on the edge that ends STOP. Back-to-back frames therefore have at least one idle cycle with Q7=1.
- D changes after acceptance have no effect on the frame in progress.
- BIT_CYCLES=1: no counter wait; each bit lasts one cycle.

Optional Feature:
- Macro: IC_74165_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - Q7 = even parity of the latched word (XOR of all bits) for one bit time.
  - Frame length becomes (WIDTH+3)*BIT_CYCLES.
- Undefined: no PARITY state, frame as above, and no parity logic is synthesised.

Test Plan:
- Reset/idle: assert RD=0 mid-simulation, then release with LOAD=0 -> Q7=1, nQ7=0, BUSY=0, DONE=0, held for 10 cycles.
- Basic frame (WIDTH=8, BIT_CYCLES=2): LOAD=1 for one cycle with D=8'hA5 -> Q7 sequence 0,1,0,1,0,0,1,0,1,1, each bit 2 cycles. BUSY high 20 cycles; DONE single pulse as BUSY falls; nQ7 always ~Q7.
- Busy/back-to-back: hold LOAD=1 with D=8'h3C, change D to 8'hFF at cycle 5 -> 8'h3C frame sent unchanged. Exactly one idle cycle with Q7=1, then a second frame starts carrying the D value present at acceptance.
- Clock enable: nCE=1 for 7 cycles during DATA bit 3 -> Q7 and counters frozen; the frame resumes and totals 27 cycles; no DONE pulse occurs while nCE=1.
- Abort: RD=0 for 3 ns at cycle 9 of a frame -> outputs reset immediately (Q7=1, BUSY=0). The next LOAD with D=8'h81 produces a clean full frame.
- Parity (macro defined): D=8'hA5 -> parity bit 0, frame 22 cycles. D=8'h07 -> parity bit 1.
